// File: rtl/trigger_window_pkg.sv
// Shared types and default widths for the trigger window capture block.
package trigger_window_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 10;

  // Capture/readout sequencing
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_ARMED,
    ST_POST,
    ST_READ
  } tw_state_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port sample buffer: one write port, one read port with a
// single registered read stage, both on the same clock.
module sdp_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Write port
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Registered read port; holds its value when not enabled
  always_ff @(posedge clk) begin
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/trigger_window_reader.sv
// Circular capture buffer with pre-trigger history. After the trigger and
// the post-trigger samples are captured, the window is streamed out over an
// AXI-Stream master through a 2-entry skid that hides the RAM read latency.
module trigger_window_reader
  import trigger_window_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_data_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  trigger_pulse,
  input  logic                  arm,
  input  logic [ADDR_WIDTH-1:0] pre_samples,
  input  logic [ADDR_WIDTH:0]   total_samples,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ADDR_WIDTH-1:0] out_trigger_offset,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_error
);

  localparam logic [ADDR_WIDTH:0]   DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO = '0;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = '0;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  tw_state_t             r_state;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH-1:0] r_fill_cnt;
  logic [ADDR_WIDTH:0]   r_post_cnt;
  logic [ADDR_WIDTH:0]   r_rd_cnt;
  logic [ADDR_WIDTH-1:0] r_pre;
  logic [ADDR_WIDTH:0]   r_total;
  logic [ADDR_WIDTH-1:0] r_trig_addr;
  logic                  r_cfg_error;
  logic                  r_done;

  // Read pipeline: one beat in flight out of the RAM, two in the skid
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic [1:0]            r_q_cnt;
  logic [DATA_WIDTH-1:0] r_q_data0;
  logic [DATA_WIDTH-1:0] r_q_data1;
  logic                  r_q_last0;
  logic                  r_q_last1;

  logic                  w_cfg_ok;
  logic                  w_capturing;
  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_fill_next;
  logic [ADDR_WIDTH:0]   w_post_len;
  logic                  w_pop;
  logic [1:0]            w_occ;
  logic                  w_rd_en;
  logic                  w_rd_last;
  logic [DATA_WIDTH-1:0] w_ram_dout;

  assign w_cfg_ok    = (total_samples != CNT_ZERO) && (total_samples <= DEPTH) &&
                       ({1'b0, pre_samples} < total_samples);
  assign w_capturing = (r_state == ST_FILL) || (r_state == ST_ARMED) || (r_state == ST_POST);
  assign w_wr_en     = in_data_valid && w_capturing;
  assign w_fill_next = r_fill_cnt + PTR_ONE;
  assign w_post_len  = r_total - {1'b0, r_pre} - CNT_ONE;

  assign m_axis_tvalid = (r_q_cnt != 2'd0);
  assign m_axis_tdata  = r_q_data0;
  assign m_axis_tlast  = r_q_last0;
  assign w_pop         = m_axis_tvalid && m_axis_tready;

  // Issue a read only if the beat is guaranteed a skid slot when it lands;
  // counting a same-cycle pop keeps one beat per cycle under full throughput.
  assign w_occ     = r_q_cnt + {1'b0, r_inflight};
  assign w_rd_en   = (r_state == ST_READ) && (r_rd_cnt < r_total) &&
                     ((w_occ < 2'd2) || ((w_occ == 2'd2) && w_pop));
  assign w_rd_last = (r_rd_cnt == (r_total - CNT_ONE));

  assign busy               = (r_state != ST_IDLE);
  assign done               = r_done;
  assign cfg_error          = r_cfg_error;
  assign out_trigger_offset = r_trig_addr;

  sdp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk      (clk),
    .i_wr_en  (w_wr_en),
    .i_wr_addr(r_wr_ptr),
    .i_wr_data(in_data),
    .i_rd_en  (w_rd_en),
    .i_rd_addr(r_rd_ptr),
    .o_rd_data(w_ram_dout)
  );

  // Capture sequencing: arm check, pre-fill, trigger, post-fill, readout
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= PTR_ZERO;
      r_rd_ptr    <= PTR_ZERO;
      r_fill_cnt  <= PTR_ZERO;
      r_post_cnt  <= CNT_ZERO;
      r_rd_cnt    <= CNT_ZERO;
      r_pre       <= PTR_ZERO;
      r_total     <= CNT_ZERO;
      r_trig_addr <= PTR_ZERO;
      r_cfg_error <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // The write pointer free-runs across windows; arming does not rewind it
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
        r_rd_cnt <= r_rd_cnt + CNT_ONE;
      end
      case (r_state)
        ST_IDLE: begin
          if (arm) begin
            if (w_cfg_ok) begin
              r_pre       <= pre_samples;
              r_total     <= total_samples;
              r_cfg_error <= 1'b0;
              r_fill_cnt  <= PTR_ZERO;
              r_rd_cnt    <= CNT_ZERO;
              r_state     <= (pre_samples == PTR_ZERO) ? ST_ARMED : ST_FILL;
            end else begin
              r_cfg_error <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          // Triggers are ignored until the pre-trigger history is complete
          if (in_data_valid) begin
            r_fill_cnt <= w_fill_next;
            if (w_fill_next == r_pre) r_state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (in_data_valid && trigger_pulse) begin
            r_trig_addr <= r_wr_ptr;
            r_rd_ptr    <= r_wr_ptr - r_pre;
            if (w_post_len == CNT_ZERO) begin
              r_state <= ST_READ;
            end else begin
              r_post_cnt <= w_post_len;
              r_state    <= ST_POST;
            end
          end
        end
        ST_POST: begin
          if (in_data_valid) begin
            r_post_cnt <= r_post_cnt - CNT_ONE;
            if (r_post_cnt == CNT_ONE) r_state <= ST_READ;
          end
        end
        ST_READ: begin
          if (w_pop && r_q_last0) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output skid: head entry drives the bus and only moves on a handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_q_cnt         <= 2'd0;
      r_q_data0       <= '0;
      r_q_data1       <= '0;
      r_q_last0       <= 1'b0;
      r_q_last1       <= 1'b0;
    end else begin
      r_inflight      <= w_rd_en;
      r_inflight_last <= w_rd_last;
      case ({r_inflight, w_pop})
        2'b01: begin
          r_q_data0 <= r_q_data1;
          r_q_last0 <= r_q_last1;
          r_q_cnt   <= r_q_cnt - 2'd1;
        end
        2'b10: begin
          if (r_q_cnt == 2'd0) begin
            r_q_data0 <= w_ram_dout;
            r_q_last0 <= r_inflight_last;
          end else begin
            r_q_data1 <= w_ram_dout;
            r_q_last1 <= r_inflight_last;
          end
          r_q_cnt <= r_q_cnt + 2'd1;
        end
        2'b11: begin
          if (r_q_cnt == 2'd1) begin
            r_q_data0 <= w_ram_dout;
            r_q_last0 <= r_inflight_last;
          end else begin
            r_q_data0 <= r_q_data1;
            r_q_last0 <= r_q_last1;
            r_q_data1 <= w_ram_dout;
            r_q_last1 <= r_inflight_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
